wvl_center_load_ctrl: RTL

//  Sequences loading of phase-center coefficients for the phase0 wavelength-conversion stage.

---
 rtl/wvl_center_load_ctrl_if.sv | 29 ++
 rtl/wvl_center_load_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wvl_center_load_ctrl_if.sv
// Bus bundle for wvl_center_load_ctrl: the staging BRAM read port and the
// center-table write port. The controller drives it through the master
// modport; the BRAM/table side uses the slave modport.
interface wvl_center_load_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] stg_addr;
  logic [DW-1:0] stg_data;
  logic          tbl_we;
  logic [AW:0]   tbl_addr;
  logic [DW-1:0] tbl_data;

  modport master (
    output stg_addr,
    input  stg_data,
    output tbl_we,
    output tbl_addr,
    output tbl_data
  );

  modport slave (
    input  stg_addr,
    output stg_data,
    input  tbl_we,
    input  tbl_addr,
    input  tbl_data
  );
endinterface

// File: rtl/wvl_center_load_ctrl.sv
// wvl_center_load_ctrl
// Copies phase-center coefficients from the staging BRAM into the shadow bank
// of a double-banked center table on a load request from the load_centers
// register, then swaps the active bank on the next frame_sync so the datapath
// only ever reads a complete table.
//
// Optional feature macro: WVL_LOAD_CHECKSUM_EN
//   When defined, adds output ld_checksum: the mod-2^32 sum of every word
//   written by the most recent completed load, published at the bank swap.
module wvl_center_load_ctrl #(
  parameter int NUM_CH = 256,
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic [31:0]            cfg_word,
  wvl_center_load_ctrl_if.master bus,
  input  logic                   frame_sync,
  output logic                   active_bank,
  output logic                   busy,
  output logic [15:0]            load_count,
  output logic                   err_overrun
`ifdef WVL_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]            ld_checksum
`endif
);

  // Highest legal table index and the final DRAIN count value.
  localparam logic [15:0] MAX_IDX    = 16'(NUM_CH - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    DRAIN     = 3'd2,
    WAIT_SYNC = 3'd3,
    SWAP      = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   cfg_last_r;   // registered cfg_word[31:16]
  logic          cfg_load_r;   // registered cfg_word[0]
  logic          load_prev_r;  // previous cfg_load_r, for edge detection
  logic          load_edge;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] last_r;
  logic [7:0]    drain_cnt_r;

  // Read pipeline: one stage per cycle of BRAM read latency. Each stage
  // carries the index in flight and the bank it must land in.
  logic          pipe_vld  [RD_LAT];
  logic [AW-1:0] pipe_idx  [RD_LAT];
  logic          pipe_bank [RD_LAT];

  // Request bits [15:1] carry no meaning for this block.
  logic          cfg_unused;
  assign cfg_unused = ^cfg_word[15:1];

  // Requested last index, clamped to the table depth.
  function automatic logic [AW-1:0] clamp_last(input logic [15:0] req);
    logic [AW-1:0] res;
    if (req > MAX_IDX) begin
      res = MAX_IDX[AW-1:0];
    end else begin
      res = req[AW-1:0];
    end
    return res;
  endfunction

  assign load_edge = cfg_load_r & ~load_prev_r;

  // Load sequencer: request capture, edge detect, and the load/swap FSM.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state       <= IDLE;
      cfg_last_r  <= 16'h0000;
      cfg_load_r  <= 1'b0;
      load_prev_r <= 1'b0;
      idx_r       <= '0;
      last_r      <= '0;
      drain_cnt_r <= 8'd0;
      active_bank <= 1'b0;
      busy        <= 1'b0;
      load_count  <= 16'h0000;
      err_overrun <= 1'b0;
    end else begin
      cfg_last_r  <= cfg_word[31:16];
      cfg_load_r  <= cfg_word[0];
      load_prev_r <= cfg_load_r;

      // A new request while a load is still in flight is dropped and flagged.
      if (busy && load_edge) begin
        err_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_edge) begin
            state       <= READ;
            busy        <= 1'b1;
            idx_r       <= '0;
            last_r      <= clamp_last(cfg_last_r);
            err_overrun <= 1'b0;
          end
        end
        READ: begin
          if (idx_r == last_r) begin
            state       <= DRAIN;
            drain_cnt_r <= 8'd0;
          end else begin
            idx_r <= idx_r + AW'(1);
          end
        end
        DRAIN: begin
          // frame_sync is deliberately not looked at until the last write
          // has retired, so a swap can never expose a partial table.
          if (drain_cnt_r == DRAIN_LAST) begin
            state <= WAIT_SYNC;
          end else begin
            drain_cnt_r <= drain_cnt_r + 8'd1;
          end
        end
        WAIT_SYNC: begin
          if (frame_sync) begin
            state       <= SWAP;
            active_bank <= ~active_bank;
            load_count  <= load_count + 16'd1;
            busy        <= 1'b0;
          end
        end
        SWAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read-to-write pipeline: delays each issued index by the BRAM latency so
  // the write lines up with its returning data.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_idx[i]  <= '0;
        pipe_bank[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= (state == READ);
      pipe_idx[0]  <= idx_r;
      pipe_bank[0] <= ~active_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
      end
    end
  end

  assign bus.stg_addr = idx_r;
  assign bus.tbl_we   = pipe_vld[RD_LAT-1];
  assign bus.tbl_addr = {pipe_bank[RD_LAT-1], pipe_idx[RD_LAT-1]};
  // Data is passed through only during a write so the port idles at zero.
  assign bus.tbl_data = pipe_vld[RD_LAT-1] ? bus.stg_data : '0;

`ifdef WVL_LOAD_CHECKSUM_EN
  logic [31:0] cksum_acc_r;

  // Checksum: accumulate written words during a load, publish at the swap.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      cksum_acc_r <= 32'h0000_0000;
      ld_checksum <= 32'h0000_0000;
    end else begin
      if ((state == IDLE) && load_edge) begin
        cksum_acc_r <= 32'h0000_0000;
      end else if (pipe_vld[RD_LAT-1]) begin
        cksum_acc_r <= cksum_acc_r + 32'(bus.tbl_data);
      end
      if ((state == WAIT_SYNC) && frame_sync) begin
        ld_checksum <= cksum_acc_r;
      end
    end
  end
`endif

endmodule
